note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Rhythm-judgement stage that sits directly downstream of the music score controller, on the same clk_1ms domain.
- Consumes note_pointer and cur_note. Detects each note onset and times player key presses against it.
- Issues PERFECT/GOOD/MISS judgements and maintains score, combo and max_combo for the display and scoring logic.

Parameters:
- PERFECT_WIN, 50, max ms after onset for a PERFECT hit.
- GOOD_WIN, 150, max ms after onset for a GOOD hit; must be > PERFECT_WIN.
- PERFECT_PTS, 10, score increment for PERFECT.
- GOOD_PTS, 5, score increment for GOOD.

Ports:
- clk_1ms  in  1  1 kHz system tick clock.
- rst  in  1  Synchronous, active-high reset.
- en  in  1  Play enable; same signal that drives the score controller.
- note_pointer  in  8  Index of the current note from the score controller.
- cur_note  in  4  Current note code; 0 = rest, 1..7 = playable.
- key_valid  in  1  One-cycle pulse marking a player key press.
- key_code  in  4  Note code of the pressed key; sampled when key_valid=1.
- judge  out  2  Last judgement: 0 NONE, 1 PERFECT, 2 GOOD, 3 MISS.
- judge_valid  out  1  One-cycle pulse when judge is updated.
- score  out  16  Accumulated score, saturating.
- combo  out  8  Current consecutive-hit count, saturating.
- max_combo  out  8  Highest combo since reset.

Behaviour:
- Reset (sync, rst=1): judge=0, judge_valid=0, score=0, combo=0, max_combo=0, state=IDLE, elapsed=0, prev_ptr=0. rst has priority over all other inputs.
- en=0: every register holds, key_valid is ignored, judge_valid=0.
- Onset detection (en=1):
  - IDLE: the first enabled cycle is an onset.
  - Otherwise: an onset is note_pointer != prev_ptr. prev_ptr is updated every enabled cycle. Wrap 255->0 counts as a change.
- elapsed: 16-bit register. Loads 0 on an onset cycle, otherwise increments each enabled cycle and saturates at 0xFFFF.
- On an onset, next state is REST if cur_note==0, else WAIT_HIT.
- States:
  - IDLE: leaves only on the first enabled cycle.
  - WAIT_HIT: note active, not yet judged.
    - key_valid=1 and key_code==cur_note and elapsed<=PERFECT_WIN -> PERFECT, go to JUDGED.
    - Same match with PERFECT_WIN < elapsed <= GOOD_WIN -> GOOD, go to JUDGED.
    - Wrong key_code, or elapsed>GOOD_WIN -> key ignored, stay in WAIT_HIT.
    - Onset while in WAIT_HIT -> MISS for the outgoing note, then enter the new note's state.
  - JUDGED: further keys ignored until the next onset.
  - REST: keys ignored; an onset leaves REST without a judgement.
- Key and onset in the same cycle: the onset wins. The outgoing note's MISS (if it was in WAIT_HIT) is issued and the key is dropped.
- Latency: the key or onset sampled at cycle t produces judge/judge_valid/score/combo updates visible at t+1. judge holds its value until the next judgement.
- Elapsed timing: the key is compared with the elapsed value present at cycle t. A key in the first cycle after the onset sees elapsed=0.
- Arithmetic:
  - score += PERFECT_PTS or GOOD_PTS, saturating at 0xFFFF.
  - combo +1 on PERFECT/GOOD, saturating at 255; combo=0 on MISS.
  - max_combo = max(max_combo, new combo), updated in the same cycle as combo.
- Reset mid-note: pending judgement discarded, no MISS emitted. Return to IDLE; the next enabled cycle is a fresh onset.

Test Plan:
- Onset of note 3 (ptr 0->1), key 3 at elapsed=20 -> next cycle: judge=1, judge_valid pulse, score=10, combo=1, max_combo=1.
- Key 5 at elapsed=120 on note 5 -> judge=2, score +5. A second key 5 at elapsed=130 -> ignored, no judge_valid.
- No key during note 2, then ptr 1->2 -> judge=3 pulse on the cycle after the change, combo 4->0, max_combo stays 4.
- Rest note (cur_note=0) with key presses, then ptr advance -> no judge_valid at any point, combo unchanged.
- Key matching the new note in the same cycle as ptr 5->6 while note 5 unjudged -> single MISS pulse; key dropped, note 6 stays in WAIT_HIT.
- Saturation and reset:
  - Preload to score=0xFFFA, combo=255, then PERFECT -> score=0xFFFF, combo=255.
  - Assert rst mid-note -> all outputs 0 one cycle later, no MISS emitted.

Source files
------------

// File: rtl/note_judge.sv
// Rhythm judgement stage: times player key presses against note onsets from the
// score controller and keeps score, combo and max_combo for display/scoring.
module note_judge #(
    parameter logic [15:0] PERFECT_WIN = 16'd50,
    parameter logic [15:0] GOOD_WIN    = 16'd150,
    parameter logic [15:0] PERFECT_PTS = 16'd10,
    parameter logic [15:0] GOOD_PTS    = 16'd5
) (
    input  logic        clk_1ms,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  note_pointer,
    input  logic [3:0]  cur_note,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [1:0]  judge,
    output logic        judge_valid,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_HIT = 2'd1,
        ST_JUDGED   = 2'd2,
        ST_REST     = 2'd3
    } state_t;

    localparam logic [1:0] J_PERFECT = 2'd1;
    localparam logic [1:0] J_GOOD    = 2'd2;
    localparam logic [1:0] J_MISS    = 2'd3;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : a + 8'd1;
    endfunction

    state_t      r_state;
    logic [15:0] r_elapsed;
    logic [7:0]  r_prev_ptr;
    logic [1:0]  r_judge;
    logic        r_judge_valid;
    logic [15:0] r_score;
    logic [7:0]  r_combo;
    logic [7:0]  r_max_combo;

    logic        w_onset;
    logic        w_match;
    logic        w_perfect;
    logic        w_good;
    logic [7:0]  w_next_combo;
    logic [15:0] w_hit_pts;

    // Onset detection and hit-window classification for the current cycle
    always_comb begin
        w_onset      = (r_state == ST_IDLE) || (note_pointer != r_prev_ptr);
        w_match      = key_valid && (key_code == cur_note) && (r_state == ST_WAIT_HIT);
        w_perfect    = w_match && (r_elapsed <= PERFECT_WIN);
        w_good       = w_match && (r_elapsed > PERFECT_WIN) && (r_elapsed <= GOOD_WIN);
        w_next_combo = sat_inc8(r_combo);
        w_hit_pts    = w_perfect ? PERFECT_PTS : GOOD_PTS;
    end

    // Judgement FSM with registered outputs; an onset always beats a same-cycle key
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_elapsed     <= 16'd0;
            r_prev_ptr    <= 8'd0;
            r_judge       <= 2'd0;
            r_judge_valid <= 1'b0;
            r_score       <= 16'd0;
            r_combo       <= 8'd0;
            r_max_combo   <= 8'd0;
        end else if (!en) begin
            r_judge_valid <= 1'b0;
        end else begin
            r_prev_ptr <= note_pointer;
            if (w_onset) begin
                r_elapsed <= 16'd0;
                r_state   <= (cur_note == 4'd0) ? ST_REST : ST_WAIT_HIT;
                if (r_state == ST_WAIT_HIT) begin
                    r_judge       <= J_MISS;
                    r_judge_valid <= 1'b1;
                    r_combo       <= 8'd0;
                end else begin
                    r_judge_valid <= 1'b0;
                end
            end else begin
                r_elapsed <= (r_elapsed == 16'hFFFF) ? r_elapsed : r_elapsed + 16'd1;
                if (w_perfect || w_good) begin
                    r_judge       <= w_perfect ? J_PERFECT : J_GOOD;
                    r_judge_valid <= 1'b1;
                    r_score       <= sat_add16(r_score, w_hit_pts);
                    r_combo       <= w_next_combo;
                    r_max_combo   <= (w_next_combo > r_max_combo) ? w_next_combo : r_max_combo;
                    r_state       <= ST_JUDGED;
                end else begin
                    r_judge_valid <= 1'b0;
                end
            end
        end
    end

    assign judge       = r_judge;
    assign judge_valid = r_judge_valid;
    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;

endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge: directed test-plan scenarios, a long
// saturation run and randomized play, all checked against a behavioural model.
module tb_note_judge;

    logic        clk_1ms = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  note_pointer = 8'd0;
    logic [3:0]  cur_note = 4'd0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [1:0]  judge;
    logic        judge_valid;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;

    int checks = 0;
    int failures = 0;

    // Reference model: a note is either awaiting a hit or not; time since onset in cycles
    bit m_started;
    bit m_pending;
    int m_since;
    int m_prev;
    int m_judge;
    int m_jv;
    int m_score;
    int m_combo;
    int m_max;

    note_judge dut (
        .clk_1ms      (clk_1ms),
        .rst          (rst),
        .en           (en),
        .note_pointer (note_pointer),
        .cur_note     (cur_note),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .judge        (judge),
        .judge_valid  (judge_valid),
        .score        (score),
        .combo        (combo),
        .max_combo    (max_combo)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_cycle(input bit r, input bit e, input int p, input int n,
                               input bit kv, input int kc);
        bit onset;
        if (r) begin
            m_started = 1'b0; m_pending = 1'b0; m_since = 0; m_prev = 0;
            m_judge = 0; m_jv = 0; m_score = 0; m_combo = 0; m_max = 0;
        end else if (!e) begin
            m_jv = 0;
        end else begin
            m_jv = 0;
            onset = !m_started || (p != m_prev);
            m_prev = p;
            m_started = 1'b1;
            if (onset) begin
                if (m_pending) begin
                    m_judge = 3; m_jv = 1; m_combo = 0;
                end
                m_pending = (n != 0);
                m_since = 0;
            end else begin
                if (m_pending && kv && kc == n && m_since <= 150) begin
                    m_judge = (m_since <= 50) ? 1 : 2;
                    m_jv = 1;
                    m_score = m_score + ((m_since <= 50) ? 10 : 5);
                    if (m_score > 65535) m_score = 65535;
                    m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
                    if (m_combo > m_max) m_max = m_combo;
                    m_pending = 1'b0;
                end
                m_since = (m_since >= 65535) ? 65535 : m_since + 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input int p, input int n,
                        input bit kv, input int kc);
        rst = r;
        en = e;
        note_pointer = p[7:0];
        cur_note = n[3:0];
        key_valid = kv;
        key_code = kc[3:0];
        model_cycle(r, e, p, n, kv, kc);
        @(posedge clk_1ms);
        #1;
        check_eq("judge", int'(judge), m_judge);
        check_eq("judge_valid", int'(judge_valid), m_jv);
        check_eq("score", int'(score), m_score);
        check_eq("combo", int'(combo), m_combo);
        check_eq("max_combo", int'(max_combo), m_max);
    endtask

    task automatic idle(input int cycles, input int p, input int n);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, p, n, 1'b0, 0);
    endtask

    initial begin
        int ptr;
        int note;
        bit r;
        bit e;
        bit kv;
        int kc;

        // Reset state
        step(1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 0, 0, 1'b0, 0);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_judge_valid", int'(judge_valid), 0);

        // First enabled cycle is an onset (rest note)
        step(1'b0, 1'b1, 0, 0, 1'b0, 0);

        // Note 3, key at elapsed=20 -> PERFECT
        step(1'b0, 1'b1, 1, 3, 1'b0, 0);
        idle(20, 1, 3);
        step(1'b0, 1'b1, 1, 3, 1'b1, 3);
        check_eq("tp1_judge", int'(judge), 1);
        check_eq("tp1_valid", int'(judge_valid), 1);
        check_eq("tp1_score", int'(score), 10);
        check_eq("tp1_combo", int'(combo), 1);
        check_eq("tp1_max", int'(max_combo), 1);

        // Note 5, key at elapsed=120 -> GOOD; second key at 130 ignored
        step(1'b0, 1'b1, 2, 5, 1'b0, 0);
        idle(120, 2, 5);
        step(1'b0, 1'b1, 2, 5, 1'b1, 5);
        check_eq("tp2_judge", int'(judge), 2);
        check_eq("tp2_score", int'(score), 15);
        idle(9, 2, 5);
        step(1'b0, 1'b1, 2, 5, 1'b1, 5);
        check_eq("tp2_second_valid", int'(judge_valid), 0);
        check_eq("tp2_second_score", int'(score), 15);

        // Two more PERFECTs -> combo 4
        step(1'b0, 1'b1, 3, 1, 1'b0, 0);
        step(1'b0, 1'b1, 3, 1, 1'b1, 1);
        step(1'b0, 1'b1, 4, 2, 1'b0, 0);
        step(1'b0, 1'b1, 4, 2, 1'b1, 2);
        check_eq("combo4", int'(combo), 4);

        // Note 6 unjudged; key for next note in same cycle as ptr 5->6 -> single MISS
        step(1'b0, 1'b1, 5, 6, 1'b0, 0);
        idle(10, 5, 6);
        step(1'b0, 1'b1, 6, 7, 1'b1, 7);
        check_eq("miss_judge", int'(judge), 3);
        check_eq("miss_valid", int'(judge_valid), 1);
        check_eq("miss_combo", int'(combo), 0);
        check_eq("miss_max", int'(max_combo), 4);
        step(1'b0, 1'b1, 6, 7, 1'b1, 7);
        check_eq("after_miss_perfect", int'(judge), 1);
        check_eq("after_miss_combo", int'(combo), 1);

        // Rest note with key presses, then advance: no judgement at all
        step(1'b0, 1'b1, 7, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 7, 0, 1'b1, i);
            check_eq("rest_valid", int'(judge_valid), 0);
        end
        step(1'b0, 1'b1, 8, 1, 1'b0, 0);
        check_eq("rest_exit_valid", int'(judge_valid), 0);
        check_eq("rest_combo", int'(combo), 1);

        // en=0 ignores a matching key
        step(1'b0, 1'b0, 8, 1, 1'b1, 1);
        check_eq("dis_valid", int'(judge_valid), 0);

        // Reset mid-note: zeros, no MISS; next enabled cycle is a fresh onset
        step(1'b1, 1'b1, 8, 1, 1'b0, 0);
        check_eq("midrst_score", int'(score), 0);
        check_eq("midrst_valid", int'(judge_valid), 0);
        check_eq("midrst_max", int'(max_combo), 0);
        step(1'b0, 1'b1, 8, 1, 1'b0, 0);
        check_eq("post_rst_valid", int'(judge_valid), 0);

        // Saturation: 6553 PERFECTs -> score 0xFFFA, combo 255 (pointer wraps)
        step(1'b1, 1'b1, 0, 0, 1'b0, 0);
        for (int i = 0; i < 6553; i++) begin
            step(1'b0, 1'b1, (i + 1) % 256, 3, 1'b0, 0);
            step(1'b0, 1'b1, (i + 1) % 256, 3, 1'b1, 3);
        end
        check_eq("pre_sat_score", int'(score), 65530);
        check_eq("pre_sat_combo", int'(combo), 255);
        step(1'b0, 1'b1, 200, 4, 1'b0, 0);
        step(1'b0, 1'b1, 200, 4, 1'b1, 4);
        check_eq("sat_score", int'(score), 65535);
        check_eq("sat_combo", int'(combo), 255);
        check_eq("sat_max", int'(max_combo), 255);

        // Randomized play against the model
        step(1'b1, 1'b1, 0, 0, 1'b0, 0);
        ptr = 0;
        note = 1;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) begin
                ptr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : (ptr + 1) % 256;
                note = $urandom_range(0, 7);
            end
            kv = ($urandom_range(0, 3) == 0);
            kc = ($urandom_range(0, 1) == 0) ? note : int'($urandom_range(0, 7));
            step(r, e, ptr, note, kv, kc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
